// File: rtl/branch_resolve_unit.sv
// Multi-cycle branch resolver: compares rs1/rs2 CHUNK bits per cycle,
// MSB chunk first, and returns eq/lt/taken/illegal over valid/ready.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous abort of any in-flight op
//   in_valid/in_ready   request handshake (rs1, rs2, funct3)
//   out_valid/out_ready result handshake (br_eq, br_lt, br_taken,
//                       br_illegal)
module branch_resolve_unit #(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_taken,
  output logic            br_illegal
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NSLOT  = 1 << CW;
  localparam logic [CW-1:0] CNT_TOP = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      f3_q, f3_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dec_q, dec_d;
  logic            lt_q, lt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            eq_o_q, eq_o_d;
  logic            lt_o_q, lt_o_d;
  logic            tk_o_q, tk_o_d;
  logic            il_o_q, il_o_d;

  // Chunk views padded to a power of two so cnt_q indexes
  // without a width mismatch; padding slots are never selected.
  logic [CHUNK-1:0] a_ch [NSLOT];
  logic [CHUNK-1:0] b_ch [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_ch
    if (g < NCHUNK) begin : g_real
      assign a_ch[g] = a_q[g*CHUNK +: CHUNK];
      assign b_ch[g] = b_q[g*CHUNK +: CHUNK];
    end else begin : g_pad
      assign a_ch[g] = '0;
      assign b_ch[g] = '0;
    end
  end

  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic             diff;
  logic             dec_nx;
  logic             lt_nx;
  logic             last;
  logic             sgn;

  assign a_cur  = a_ch[cnt_q];
  assign b_cur  = b_ch[cnt_q];
  assign diff   = (a_cur != b_cur);
  assign dec_nx = dec_q | diff;
  // Only the most significant differing chunk decides lt.
  assign lt_nx  = dec_q ? lt_q : (diff && (a_cur < b_cur));
  assign last   = (cnt_q == '0) ||
                  ((EARLY_EXIT != 0) && diff);
  assign sgn    = (funct3[2:1] == 2'b10);

  function automatic logic taken_f(
    input logic [2:0] f,
    input logic       eq,
    input logic       lt
  );
    logic t;
    t = 1'b0;
    unique case (1'b1)
      f == 3'b000:                  t = eq;
      f == 3'b001:                  t = !eq;
      f == 3'b100, f == 3'b110:     t = lt;
      f == 3'b101, f == 3'b111:     t = !lt;
      default:                      t = 1'b0;
    endcase
    return t;
  endfunction

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    lt_d        = lt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    eq_o_d      = eq_o_q;
    lt_o_d      = lt_o_q;
    tk_o_d      = tk_o_q;
    il_o_d      = il_o_q;

    if (flush) begin
      state_d     = S_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            // Flipping the sign bits maps signed order
            // onto unsigned order.
            a_d = rs1;
            b_d = rs2;
            a_d[XLEN-1] = rs1[XLEN-1] ^ sgn;
            b_d[XLEN-1] = rs2[XLEN-1] ^ sgn;
            f3_d       = funct3;
            cnt_d      = CNT_TOP;
            dec_d      = 1'b0;
            lt_d       = 1'b0;
            in_ready_d = 1'b0;
            state_d    = S_CMP;
          end
        end
        S_CMP: begin
          dec_d = dec_nx;
          lt_d  = lt_nx;
          if (last) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            eq_o_d      = !dec_nx;
            lt_o_d      = lt_nx;
            tk_o_d      = taken_f(f3_q, !dec_nx, lt_nx);
            il_o_d      = (f3_q[2:1] == 2'b01);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f3_q        <= '0;
      cnt_q       <= CNT_TOP;
      dec_q       <= 1'b0;
      lt_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      eq_o_q      <= 1'b0;
      lt_o_q      <= 1'b0;
      tk_o_q      <= 1'b0;
      il_o_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f3_q        <= f3_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      lt_q        <= lt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      eq_o_q      <= eq_o_d;
      lt_o_q      <= lt_o_d;
      tk_o_q      <= tk_o_d;
      il_o_q      <= il_o_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign br_eq      = eq_o_q;
  assign br_lt      = lt_o_q;
  assign br_taken   = tk_o_q;
  assign br_illegal = il_o_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: four configurations (CHUNK 8,
// 8 with early exit, 32, 4) checked against a behavioural model.
module tb_branch_resolve_unit;

  localparam int NI = 4;
  localparam int CH_W [NI] = '{8, 8, 32, 4};
  localparam int EE_P [NI] = '{0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rs1, rs2;
  logic [2:0]  funct3;
  logic iv [NI];
  logic fl [NI];
  logic ordy [NI];
  logic ir [NI];
  logic ov [NI];
  logic eq [NI];
  logic lt [NI];
  logic tk [NI];
  logic il [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    branch_resolve_unit #(
      .XLEN(32),
      .CHUNK(CH_W[g]),
      .EARLY_EXIT(EE_P[g])
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(fl[g]),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .rs1(rs1),
      .rs2(rs2),
      .funct3(funct3),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .br_eq(eq[g]),
      .br_lt(lt[g]),
      .br_taken(tk[g]),
      .br_illegal(il[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int nch(input int i);
    return 32 / CH_W[i];
  endfunction

  // Cycles from accept to out_valid.
  function automatic int exp_lat(input int i,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] x;
    int p;
    x = a ^ b;
    if (EE_P[i] == 0 || x == 0) return nch(i);
    p = 31;
    while (!x[p]) p--;
    return nch(i) - p / CH_W[i];
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, output logic e,
                       output logic l, output logic t,
                       output logic x);
    e = (a == b);
    if (f[2:1] == 2'b10) l = ($signed(a) < $signed(b));
    else l = (a < b);
    case (f)
      3'b000: t = e;
      3'b001: t = !e;
      3'b100, 3'b110: t = l;
      3'b101, 3'b111: t = !l;
      default: t = 1'b0;
    endcase
    x = (f == 3'b010) || (f == 3'b011);
  endtask

  task automatic run_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] f,
                        input int hold, input string tag);
    logic e, l, t, x;
    int n;
    model(a, b, f, e, l, t, x);
    n = 0;
    while (!ir[i] && n < 50) begin
      step;
      n++;
    end
    chk({tag, "_rdy"}, ir[i], 1);
    rs1 = a;
    rs2 = b;
    funct3 = f;
    iv[i] = 1'b1;
    step;
    iv[i] = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    funct3 = 3'($urandom_range(7));
    chk({tag, "_busy"}, ir[i], 0);
    n = 0;
    while (!ov[i] && n < 40) begin
      step;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat(i, a, b));
    chk({tag, "_eq"}, eq[i], e);
    chk({tag, "_lt"}, lt[i], l);
    chk({tag, "_tk"}, tk[i], t);
    chk({tag, "_il"}, il[i], x);
    for (int h = 0; h < hold; h++) begin
      iv[i] = 1'b1;
      step;
      chk({tag, "_hold_ov"}, ov[i], 1);
      chk({tag, "_hold_rdy"}, ir[i], 0);
      chk({tag, "_hold_res"}, {eq[i], lt[i], tk[i], il[i]},
          {e, l, t, x});
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    step;
    ordy[i] = 1'b0;
    chk({tag, "_rel_ov"}, ov[i], 0);
    chk({tag, "_rel_rdy"}, ir[i], 1);
  endtask

  initial begin
    logic [31:0] a, b;
    int seen, n;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0;
      fl[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    rs1 = '0;
    rs2 = '0;
    funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_rdy", ir[i], 1);
      chk("rst_out", {ov[i], eq[i], lt[i], tk[i], il[i]}, 0);
    end
    rst_n = 1'b1;
    step;

    run_op(0, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0, "beq");
    run_op(0, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, "blt");
    run_op(0, 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, "bltu");
    run_op(1, 32'h12000000, 32'h13000000, 3'b111, 0, "ee_bgeu");
    run_op(1, 32'h12345678, 32'h12345678, 3'b000, 0, "ee_eq");
    run_op(1, 32'h12345678, 32'h12345679, 3'b101, 0, "ee_lsb");
    run_op(0, 32'h80000000, 32'h7FFFFFFF, 3'b101, 5, "bp");
    run_op(0, 32'h00000005, 32'h00000007, 3'b010, 0, "ill");

    // Flush during the second compare cycle.
    rs1 = 32'h1;
    rs2 = 32'h2;
    funct3 = 3'b100;
    iv[0] = 1'b1;
    step;
    iv[0] = 1'b0;
    step;
    fl[0] = 1'b1;
    step;
    fl[0] = 1'b0;
    chk("flush_rdy", ir[0], 1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ov[0]) seen++;
      step;
    end
    chk("flush_nov", seen, 0);

    // A request that coincides with flush is dropped.
    iv[0] = 1'b1;
    fl[0] = 1'b1;
    step;
    iv[0] = 1'b0;
    fl[0] = 1'b0;
    chk("flush_noacc", ir[0], 1);

    // Flush beats the output handshake in DONE.
    rs1 = 32'h5;
    rs2 = 32'h5;
    iv[0] = 1'b1;
    step;
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      step;
      n++;
    end
    chk("fdone_ov", ov[0], 1);
    fl[0] = 1'b1;
    ordy[0] = 1'b1;
    step;
    fl[0] = 1'b0;
    ordy[0] = 1'b0;
    chk("fdone_out", {ov[0], ir[0]}, 2'b01);

    // Async reset mid-compare after a result with lt/taken set.
    run_op(0, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, "pre_rst");
    rs1 = 32'h10;
    rs2 = 32'h20;
    iv[0] = 1'b1;
    step;
    iv[0] = 1'b0;
    step;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {ov[0], eq[0], lt[0], tk[0], il[0]}, 0);
    chk("arst_rdy", ir[0], 1);
    #2;
    rst_n = 1'b1;
    step;

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 40; k++) begin
        a = $urandom;
        case ($urandom_range(3))
          0: b = a;
          1: b = a ^ (32'h1 << $urandom_range(31));
          2: b = {~a[31], a[30:0]};
          default: b = $urandom;
        endcase
        if ($urandom_range(1) == 1) begin
          run_op(i, a, b, 3'($urandom_range(7)),
                 $urandom_range(2), "rnd");
        end else begin
          run_op(i, b, a, 3'($urandom_range(7)),
                 $urandom_range(2), "rnd");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
